// File: rtl/pc_ctrl.sv
// Program-counter sequencer: fetch/decode/execute FSM with a 4-deep return stack.
// Drives the PC register's enable, source select and load target.
module pc_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic [15:0] instr,
  input  logic        zero_flag,
  input  logic [7:0]  PC,
  output logic        fetch_req,
  output logic        pc_en,
  output logic        PCsrc,
  output logic [7:0]  immediate,
  output logic        exec_en,
  output logic        halted,
  output logic        stack_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'h2;
  localparam logic [3:0] OP_BNE  = 4'h3;
  localparam logic [3:0] OP_CALL = 4'h4;
  localparam logic [3:0] OP_RET  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic              zero_q, zero_d;
  logic              take_q, take_d;
  logic [7:0]        target_q, target_d;
  logic [2:0]        sp_q, sp_d;
  logic [3:0][7:0]   stack_q, stack_d;
  logic              stack_err_q, stack_err_d;

  logic [3:0] opcode;
  logic [7:0] imm;
  logic [1:0] top_idx;
  logic [7:0] pc_inc;
  logic       exec_src;

  assign opcode  = ir_q[15:12];
  assign imm     = ir_q[7:0];
  assign top_idx = sp_q[1:0] - 2'd1;
  assign pc_inc  = PC + 8'd1;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      ir_q        <= 16'h0000;
      zero_q      <= 1'b0;
      take_q      <= 1'b0;
      target_q    <= 8'h00;
      sp_q        <= 3'd0;
      stack_q     <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      zero_q      <= zero_d;
      take_q      <= take_d;
      target_q    <= target_d;
      sp_q        <= sp_d;
      stack_q     <= stack_d;
      stack_err_q <= stack_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = (opcode == OP_HALT) ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Decode resolves the jump target and stack legality up front, so EXEC
  // only commits the push/pop that was already judged safe (take_q).
  always_comb begin
    ir_d        = ir_q;
    zero_d      = zero_q;
    take_d      = take_q;
    target_d    = target_q;
    sp_d        = sp_q;
    stack_d     = stack_q;
    stack_err_d = stack_err_q;
    case (state_q)
      FETCH: if (mem_ready) ir_d = instr;
      DECODE: begin
        zero_d   = zero_flag;
        take_d   = 1'b0;
        target_d = imm;
        case (opcode)
          OP_JMP: take_d = 1'b1;
          OP_CALL: begin
            if (sp_q == 3'd4) stack_err_d = 1'b1;
            else              take_d      = 1'b1;
          end
          OP_RET: begin
            if (sp_q == 3'd0) stack_err_d = 1'b1;
            else begin
              take_d   = 1'b1;
              target_d = stack_q[top_idx];
            end
          end
          default: take_d = 1'b0;
        endcase
      end
      EXEC: begin
        if (opcode == OP_CALL && take_q) begin
          stack_d[sp_q[1:0]] = pc_inc;
          sp_d               = sp_q + 3'd1;
        end else if (opcode == OP_RET && take_q) begin
          sp_d = sp_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_BEQ:  exec_src = zero_q;
      OP_BNE:  exec_src = !zero_q;
      default: exec_src = take_q;
    endcase
  end

  // Datapath opcodes raise exec_en alongside pc_en so the PC still advances.
  always_comb begin
    fetch_req = 1'b0;
    pc_en     = 1'b0;
    PCsrc     = 1'b0;
    immediate = 8'h00;
    exec_en   = 1'b0;
    halted    = 1'b0;
    stack_err = 1'b0;
    if (reset) begin
      stack_err = stack_err_q && (state_q != HALT) && (state_q != IDLE);
      case (state_q)
        FETCH: fetch_req = 1'b1;
        EXEC: begin
          pc_en     = (opcode != OP_HALT);
          exec_en   = (opcode > OP_RET) && (opcode != OP_HALT);
          PCsrc     = exec_src && (opcode != OP_HALT) && (opcode != OP_NOP);
          immediate = PCsrc ? target_q : 8'h00;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed-vector bench for pc_ctrl: each record gives the inputs for one cycle
// and the outputs expected in that same cycle, before the next rising edge.
module tb_pc_ctrl;

  logic        CLK;
  logic        reset;
  logic        mem_ready;
  logic [15:0] instr;
  logic        zero_flag;
  logic [7:0]  PC;
  logic        fetch_req, pc_en, PCsrc, exec_en, halted, stack_err;
  logic [7:0]  immediate;

  typedef struct {
    logic        rst;
    logic        mr;
    logic [15:0] ins;
    logic        zf;
    logic [7:0]  pc;
    logic        fr;
    logic        pe;
    logic        ps;
    logic [7:0]  im;
    logic        ee;
    logic        h;
    logic        se;
  } vec_t;

  vec_t vecs[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  pc_ctrl dut (
    .CLK       (CLK),
    .reset     (reset),
    .mem_ready (mem_ready),
    .instr     (instr),
    .zero_flag (zero_flag),
    .PC        (PC),
    .fetch_req (fetch_req),
    .pc_en     (pc_en),
    .PCsrc     (PCsrc),
    .immediate (immediate),
    .exec_en   (exec_en),
    .halted    (halted),
    .stack_err (stack_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic add_vec(input logic rst, input logic mr, input logic [15:0] ins,
                         input logic zf, input logic [7:0] pc,
                         input logic fr, input logic pe, input logic ps,
                         input logic [7:0] im, input logic ee, input logic h,
                         input logic se);
    vec_t v;
    v.rst = rst; v.mr = mr; v.ins = ins; v.zf = zf; v.pc = pc;
    v.fr = fr; v.pe = pe; v.ps = ps; v.im = im; v.ee = ee; v.h = h; v.se = se;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    mem_ready = v.mr;
    instr     = v.ins;
    zero_flag = v.zf;
    PC        = v.pc;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [13:0] got, want;
    got  = {fetch_req, pc_en, PCsrc, exec_en, halted, stack_err, immediate};
    want = {v.fr, v.pe, v.ps, v.ee, v.h, v.se, v.im};
    vectors_applied++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got fr=%b pe=%b ps=%b ee=%b h=%b se=%b im=%h, expected fr=%b pe=%b ps=%b ee=%b h=%b se=%b im=%h",
               name, fetch_req, pc_en, PCsrc, exec_en, halted, stack_err, immediate,
               v.fr, v.pe, v.ps, v.ee, v.h, v.se, v.im);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput(name, v);
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string name, input logic rst, input logic mr,
                      input logic [15:0] ins, input logic zf, input logic [7:0] pc,
                      input logic fr, input logic pe, input logic ps,
                      input logic [7:0] im, input logic ee, input logic h,
                      input logic se);
    vec_t v;
    v.rst = rst; v.mr = mr; v.ins = ins; v.zf = zf; v.pc = pc;
    v.fr = fr; v.pe = pe; v.ps = ps; v.im = im; v.ee = ee; v.h = h; v.se = se;
    run_vec(name, v);
  endtask

  initial begin
    //       rst mr  instr    zf pc      fr pe ps im     ee h  se
    add_vec(0, 1, 16'h0000, 0, 8'h05,  0, 0, 0, 8'h00, 0, 0, 0); // in reset
    add_vec(1, 1, 16'h0000, 0, 8'h05,  0, 0, 0, 8'h00, 0, 0, 0); // IDLE
    add_vec(1, 1, 16'h0000, 0, 8'h05,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH NOP
    add_vec(1, 0, 16'h0000, 0, 8'h05,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE
    add_vec(1, 0, 16'h0000, 0, 8'h05,  0, 1, 0, 8'h00, 0, 0, 0); // EXEC NOP
    add_vec(1, 0, 16'hFFFF, 0, 8'h06,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH wait 1
    add_vec(1, 0, 16'hFFFF, 0, 8'h06,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH wait 2
    add_vec(1, 0, 16'hFFFF, 0, 8'h06,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH wait 3
    add_vec(1, 1, 16'h1010, 0, 8'h06,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH JMP
    add_vec(1, 1, 16'hF0FF, 0, 8'h06,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE, instr ignored
    add_vec(1, 1, 16'hF0FF, 0, 8'h06,  0, 1, 1, 8'h10, 0, 0, 0); // EXEC JMP
    add_vec(1, 1, 16'h2020, 0, 8'h10,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH BEQ
    add_vec(1, 0, 16'h0000, 1, 8'h10,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE zf=1
    add_vec(1, 0, 16'h0000, 0, 8'h10,  0, 1, 1, 8'h20, 0, 0, 0); // EXEC BEQ taken
    add_vec(1, 1, 16'h3020, 0, 8'h20,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH BNE
    add_vec(1, 0, 16'h0000, 1, 8'h20,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE zf=1
    add_vec(1, 0, 16'h0000, 0, 8'h20,  0, 1, 0, 8'h00, 0, 0, 0); // EXEC BNE not taken
    add_vec(1, 1, 16'h7055, 0, 8'h21,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH datapath op
    add_vec(1, 1, 16'h0000, 0, 8'h21,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE
    add_vec(1, 1, 16'h0000, 0, 8'h21,  0, 1, 0, 8'h00, 1, 0, 0); // EXEC exec_en
    add_vec(1, 1, 16'h4030, 0, 8'hFF,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH CALL @FF
    add_vec(1, 0, 16'h0000, 0, 8'hFF,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE
    add_vec(1, 0, 16'h0000, 0, 8'hFF,  0, 1, 1, 8'h30, 0, 0, 0); // EXEC CALL
    add_vec(1, 1, 16'h5000, 0, 8'h30,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH RET
    add_vec(1, 0, 16'h0000, 0, 8'h30,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE
    add_vec(1, 0, 16'h0000, 0, 8'h30,  0, 1, 1, 8'h00, 0, 0, 0); // EXEC RET -> 00
    add_vec(1, 1, 16'h5000, 0, 8'h00,  1, 0, 0, 8'h00, 0, 0, 0); // FETCH RET again
    add_vec(1, 0, 16'h0000, 0, 8'h00,  0, 0, 0, 8'h00, 0, 0, 0); // DECODE
    add_vec(1, 0, 16'h0000, 0, 8'h00,  0, 1, 0, 8'h00, 0, 0, 1); // EXEC underflow
    add_vec(1, 0, 16'h0000, 0, 8'h01,  1, 0, 0, 8'h00, 0, 0, 1); // FETCH, err sticky
    add_vec(0, 1, 16'h1010, 0, 8'h01,  0, 0, 0, 8'h00, 0, 0, 0); // reset mid-FETCH
    add_vec(1, 1, 16'h1010, 0, 8'h01,  0, 0, 0, 8'h00, 0, 0, 0); // IDLE, err cleared

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Overflow: the fifth CALL is refused and the stack keeps its four entries.
    for (int k = 0; k < 5; k++) begin
      step($sformatf("call%0d_fetch", k), 1, 1, 16'h4040, 0, 8'(k),
           1, 0, 0, 8'h00, 0, 0, 0);
      step($sformatf("call%0d_decode", k), 1, 0, 16'h0000, 0, 8'(k),
           0, 0, 0, 8'h00, 0, 0, 0);
      step($sformatf("call%0d_exec", k), 1, 0, 16'h0000, 0, 8'(k),
           0, 1, (k < 4), (k < 4) ? 8'h40 : 8'h00, 0, 0, (k == 4));
    end

    // Unwind: pops must return 4,3,2,1 (PC+1 of each accepted CALL).
    for (int j = 0; j < 4; j++) begin
      step($sformatf("ret%0d_fetch", j), 1, 1, 16'h5000, 0, 8'h40,
           1, 0, 0, 8'h00, 0, 0, 1);
      step($sformatf("ret%0d_decode", j), 1, 0, 16'h0000, 0, 8'h40,
           0, 0, 0, 8'h00, 0, 0, 1);
      step($sformatf("ret%0d_exec", j), 1, 0, 16'h0000, 0, 8'h40,
           0, 1, 1, 8'(4 - j), 0, 0, 1);
    end

    step("halt_fetch",  1, 1, 16'hF000, 0, 8'h01, 1, 0, 0, 8'h00, 0, 0, 1);
    step("halt_decode", 1, 0, 16'h0000, 0, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    step("halt_exec",   1, 0, 16'h0000, 0, 8'h01, 0, 0, 0, 8'h00, 0, 0, 1);
    for (int n = 0; n < 3; n++)
      step($sformatf("halted%0d", n), 1, 1, 16'h1010, 1, 8'h01,
           0, 0, 0, 8'h00, 0, 1, 0);
    step("halt_reset",   0, 1, 16'h0000, 0, 8'h01, 0, 0, 0, 8'h00, 0, 0, 0);
    step("after_idle",   1, 1, 16'h0000, 0, 8'h01, 0, 0, 0, 8'h00, 0, 0, 0);
    step("after_fetch",  1, 0, 16'h0000, 0, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
